// File: rtl/cfg_pwm_timer.sv
// Prescaled 16-bit timer/PWM fed by the SPI config bank.
// Shadowed period/compare, wrap/match flags, snapshot readback.
module cfg_pwm_timer #(
   parameter int NUM_CFG    = 8,
   parameter int NUM_STATUS = 8,
   parameter int REG_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ena,
   input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
   output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
   output logic                            pwm_out,
   output logic                            irq
);

   localparam int CW = 2 * REG_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_count;
   logic [REG_WIDTH-1:0] r_psc;
   logic [CW-1:0]        r_sh_per;
   logic [CW-1:0]        r_sh_cmp;
   logic [CW-1:0]        r_snap;
   logic [REG_WIDTH-1:0] r_ovf_cnt;
   logic [5:0]           r_cfg0_q;
   logic                 r_ovf;
   logic                 r_match;
   logic                 r_done;
   logic                 r_pwm;
   logic                 r_irq;

   logic [REG_WIDTH-1:0] w_cfg0;
   logic [CW-1:0]        w_period;
   logic [CW-1:0]        w_compare;
   logic [REG_WIDTH-1:0] w_presc;
   logic [5:0]           w_rise;
   logic                 w_start;
   logic                 w_tick;
   logic                 w_wrap;
   logic                 w_match;
   logic [CW-1:0]        w_next;
   logic [REG_WIDTH-1:0] w_ovf_base;
   logic                 w_unused;

   assign w_cfg0    = config_regs[0 +: REG_WIDTH];
   assign w_period  = {config_regs[2*REG_WIDTH +: REG_WIDTH],
                       config_regs[1*REG_WIDTH +: REG_WIDTH]};
   assign w_compare = {config_regs[4*REG_WIDTH +: REG_WIDTH],
                       config_regs[3*REG_WIDTH +: REG_WIDTH]};
   assign w_presc   = config_regs[5*REG_WIDTH +: REG_WIDTH];

   assign w_rise  = w_cfg0[5:0] & ~r_cfg0_q;
   assign w_start = w_rise[0] & (r_state != S_RUN);
   assign w_tick  = (r_psc == w_presc);
   assign w_wrap  = w_tick & (r_count == r_sh_per);
   assign w_next  = w_wrap ? '0 : r_count + 1'b1;
   assign w_match = w_tick & (w_next == r_sh_cmp);

   // a clear coinciding with a wrap still counts that wrap
   assign w_ovf_base = w_rise[2] ? '0 : r_ovf_cnt;

   assign w_unused = ^{config_regs[NUM_CFG*REG_WIDTH-1:6*REG_WIDTH],
                       w_cfg0[REG_WIDTH-1:6], w_rise[5:4], w_rise[1]};

   assign pwm_out = r_pwm;
   assign irq     = r_irq;

   assign status_regs = {
      {((NUM_STATUS-4)*REG_WIDTH){1'b0}},
      r_ovf_cnt,
      r_snap,
      {(REG_WIDTH-4){1'b0}},
      r_done, r_match, r_ovf, (r_state == S_RUN)
   };

   // cfg0 edge-detect history and atomic count snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg0_q <= '0;
         r_snap   <= '0;
      end else if (ena) begin
         r_cfg0_q <= w_cfg0[5:0];
         if (w_rise[3]) r_snap <= r_count;
      end
   end

   // control FSM with counter, flags and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_psc     <= '0;
         r_sh_per  <= '0;
         r_sh_cmp  <= '0;
         r_ovf_cnt <= '0;
         r_ovf     <= 1'b0;
         r_match   <= 1'b0;
         r_done    <= 1'b0;
         r_pwm     <= 1'b0;
         r_irq     <= 1'b0;
      end else if (ena) begin
         r_pwm <= (r_state == S_RUN) && (r_count < r_sh_cmp);
         r_irq <= (r_match & w_cfg0[4]) | (r_ovf & w_cfg0[5]);
         if (w_rise[2]) begin
            r_ovf     <= 1'b0;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
            r_ovf_cnt <= '0;
         end
         if (w_start) begin
            r_state  <= S_RUN;
            r_sh_per <= w_period;
            r_sh_cmp <= w_compare;
            r_count  <= '0;
            r_psc    <= '0;
            r_done   <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: r_state <= S_IDLE;
               S_DONE: if (!w_cfg0[0]) r_state <= S_IDLE;
               S_RUN: begin
                  if (!w_cfg0[0]) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_psc <= w_tick ? '0 : r_psc + 1'b1;
                     if (w_tick) begin
                        r_count <= w_next;
                        if (w_match) r_match <= 1'b1;
                        if (w_wrap) begin
                           r_ovf     <= 1'b1;
                           r_ovf_cnt <= (&w_ovf_base) ? w_ovf_base
                                                      : w_ovf_base + 1'b1;
                           r_sh_per  <= w_period;
                           r_sh_cmp  <= w_compare;
                           if (w_cfg0[1]) begin
                              r_state <= S_DONE;
                              r_done  <= 1'b1;
                           end
                        end
                     end
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cfg_pwm_timer.sv
// Self-checking bench for cfg_pwm_timer.
// Directed scenarios plus random stimulus against a behavioural model.
module tb_cfg_pwm_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic [63:0] config_regs;
   logic [63:0] status_regs;
   logic        pwm_out;
   logic        irq;

   logic [7:0]  c0, presc, j6, j7;
   logic [15:0] per, cmp;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state (state: 0 idle, 1 run, 2 done)
   int         m_st, m_cnt, m_psc, m_per, m_cmp, m_snap, m_ocnt;
   bit         m_ovf, m_match, m_done, m_pwm, m_irq;
   logic [7:0] m_prev;

   assign config_regs = {j7, j6, presc, cmp, per, c0};

   always #5 clk = ~clk;

   cfg_pwm_timer #(
      .NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .config_regs(config_regs),
      .status_regs(status_regs),
      .pwm_out(pwm_out),
      .irq(irq)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_st = 0; m_cnt = 0; m_psc = 0; m_per = 0; m_cmp = 0;
      m_snap = 0; m_ocnt = 0;
      m_ovf = 0; m_match = 0; m_done = 0; m_pwm = 0; m_irq = 0;
      m_prev = 8'h00;
   endtask

   task automatic m_step();
      logic [7:0] rise;
      bit np, ni, tick, wrap;
      int nc;
      if (rst) begin
         m_reset();
         return;
      end
      if (!ena) return;
      rise = c0 & ~m_prev;
      np = (m_st == 1) && (m_cnt < m_cmp);
      ni = (m_match && c0[4]) || (m_ovf && c0[5]);
      if (rise[3]) m_snap = m_cnt;
      if (rise[2]) begin
         m_ovf = 0; m_match = 0; m_done = 0; m_ocnt = 0;
      end
      if (m_st != 1 && rise[0]) begin
         m_st = 1; m_per = per; m_cmp = cmp;
         m_cnt = 0; m_psc = 0; m_done = 0;
      end else if (m_st != 0 && !c0[0]) begin
         m_st = 0;
      end else if (m_st == 1) begin
         tick = (m_psc == presc);
         m_psc = tick ? 0 : (m_psc + 1) % 256;
         if (tick) begin
            wrap = (m_cnt == m_per);
            nc = wrap ? 0 : m_cnt + 1;
            if (nc == m_cmp) m_match = 1;
            if (wrap) begin
               m_ovf = 1;
               m_ocnt = (m_ocnt < 255) ? m_ocnt + 1 : 255;
               m_per = per;
               m_cmp = cmp;
               if (c0[1]) begin
                  m_st = 2;
                  m_done = 1;
               end
            end
            m_cnt = nc;
         end
      end
      m_pwm = np;
      m_irq = ni;
      m_prev = c0;
   endtask

   function automatic logic [63:0] m_status();
      logic [7:0]  oc;
      logic [15:0] sn;
      oc = 8'(m_ocnt);
      sn = 16'(m_snap);
      return {32'h0, oc, sn, 4'h0, m_done, m_match, m_ovf, (m_st == 1)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      m_step();
      #1;
      chk("pwm", 64'(pwm_out), 64'(m_pwm));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("status", status_regs, m_status());
   endtask

   initial begin
      int highs, w1, w2;
      rst = 1'b1; ena = 1'b1; c0 = 8'h00;
      per = 16'h0; cmp = 16'h0; presc = 8'h0;
      j6 = 8'($urandom); j7 = 8'($urandom);
      m_reset();
      repeat (2) cyc();
      rst = 1'b0;
      cyc();

      // count to 0x40, snapshot, then reset mid-run
      per = 16'hFFFF; cmp = 16'h0100; presc = 8'h00;
      c0 = 8'h01; cyc();
      repeat (64) cyc();
      c0 = 8'h09; cyc();
      chk("snap40", 64'(status_regs[23:8]), 64'h0040);
      rst = 1'b1;
      #1;
      chk("rst_status", status_regs, 64'h0);
      chk("rst_pwm", 64'(pwm_out), 64'h0);
      chk("rst_irq", 64'(irq), 64'h0);
      cyc();
      rst = 1'b0; c0 = 8'h00;
      cyc();

      // basic PWM duty and ovf_cnt saturation
      per = 16'd9; cmp = 16'd3; presc = 8'd0;
      c0 = 8'h04; cyc();
      c0 = 8'h01; cyc();
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         highs += int'(pwm_out);
      end
      chk("pwm_duty", 64'(highs), 64'd6);
      chk("ovf_set", 64'(status_regs[1]), 64'h1);
      per = 16'd0;
      repeat (300) cyc();
      chk("ocnt_sat", 64'(status_regs[31:24]), 64'hFF);
      c0 = 8'h00; cyc();

      // prescaler and snapshot
      per = 16'hFFFF; presc = 8'd3;
      c0 = 8'h04; cyc();
      c0 = 8'h01; cyc();
      repeat (41) cyc();
      c0 = 8'h09; cyc();
      chk("snap_psc", 64'(status_regs[23:8]), 64'h000A);
      c0 = 8'h00; cyc();

      // one-shot, then restart
      per = 16'd4; cmp = 16'd2; presc = 8'd0;
      c0 = 8'h04; cyc();
      c0 = 8'h03; cyc();
      repeat (8) cyc();
      chk("oneshot_st0", 64'(status_regs[7:0]), 64'h0E);
      chk("oneshot_pwm", 64'(pwm_out), 64'h0);
      chk("oneshot_ocnt", 64'(status_regs[31:24]), 64'h01);
      c0 = 8'h02; cyc();
      c0 = 8'h03; cyc();
      chk("restart", 64'(status_regs[7:0] & 8'h09), 64'h01);
      c0 = 8'h00; cyc();

      // shadow update takes effect only at the wrap
      per = 16'd9; cmp = 16'd5; presc = 8'd0;
      c0 = 8'h04; cyc();
      c0 = 8'h01; cyc();
      w1 = 0; w2 = 0;
      for (int i = 1; i <= 60; i++) begin
         if (i == 4) per = 16'd19;
         cyc();
         if (status_regs[31:24] == 8'd1 && w1 == 0) w1 = i;
         if (status_regs[31:24] == 8'd2 && w2 == 0) w2 = i;
      end
      chk("shadow_w1", 64'(w1), 64'd10);
      chk("shadow_w2", 64'(w2), 64'd30);
      c0 = 8'h00; cyc();

      // interrupt on overflow, then clear
      per = 16'd0; cmp = 16'd0;
      c0 = 8'h04; cyc();
      c0 = 8'h21; cyc();
      cyc(); cyc();
      chk("irq_on", 64'(irq), 64'h1);
      c0 = 8'h24; cyc();
      cyc();
      chk("irq_off", 64'(irq), 64'h0);
      chk("clr_ocnt", 64'(status_regs[31:24]), 64'h0);

      // ena low freezes the counter
      per = 16'hFFFF; presc = 8'd0;
      c0 = 8'h01; cyc();
      repeat (10) cyc();
      ena = 1'b0;
      repeat (20) cyc();
      ena = 1'b1;
      c0 = 8'h09; cyc();
      chk("ena_hold", 64'(status_regs[23:8]), 64'd10);
      c0 = 8'h00; cyc();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) per = 16'($urandom_range(0, 12));
         if ($urandom_range(0, 9) == 0) cmp = 16'($urandom_range(0, 14));
         if ($urandom_range(0, 19) == 0) presc = 8'($urandom_range(0, 2));
         if ($urandom_range(0, 5) == 0) c0[$urandom_range(0, 5)] ^= 1'b1;
         if ($urandom_range(0, 49) == 0) j6 = 8'($urandom);
         if ($urandom_range(0, 49) == 0) j7 = 8'($urandom);
         ena = ($urandom_range(0, 15) != 0);
         rst = ($urandom_range(0, 499) == 0);
         cyc();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
